// File: rtl/pi_pkg.sv
// Shared definitions for the PI loop sequencer.
//   - FSM state encoding (IDLE / WAIT / OUTPUT)
//   - default arithmetic pipeline latency
//   - clamp-limit helpers, parameterised by the DAC word width
package pi_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    localparam int DEFAULT_PIPELINE_LATENCY = 5;

    // Largest positive value of a range_bits-wide signed word: 2^(R-1)-1.
    function automatic logic [63:0] clamp_pos_limit(input int range_bits);
        return (64'd1 << (range_bits - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative range_bits-wide signed word: -2^(R-1).
    // Only the low range_bits bits are meaningful.
    function automatic logic [63:0] clamp_neg_limit(input int range_bits);
        return 64'd1 << (range_bits - 1);
    endfunction

endpackage

// File: rtl/pi_output_clamp.sv
// Combinational output clamp for the PI loop.
// Ports:
//   pi_result  - raw pipeline result (OUTPUT_WIDTH)
//   overflow   - pipeline says result is above the DAC range
//   underflow  - pipeline says result is below the DAC range
//   dac_word   - word to present to the DAC (OUTPUT_RANGE_BITS)
//   clamped    - dac_word is a saturation limit
//   commit_en  - the new integral may be committed (no saturation)
module pi_output_clamp
    import pi_pkg::*;
#(
    parameter int OUTPUT_WIDTH      = 32,
    parameter int OUTPUT_RANGE_BITS = 20
) (
    input  logic [OUTPUT_WIDTH-1:0]      pi_result,
    input  logic                         overflow,
    input  logic                         underflow,
    output logic [OUTPUT_RANGE_BITS-1:0] dac_word,
    output logic                         clamped,
    output logic                         commit_en
);

    localparam logic [OUTPUT_RANGE_BITS-1:0] POS_LIMIT =
        OUTPUT_RANGE_BITS'(clamp_pos_limit(OUTPUT_RANGE_BITS));
    localparam logic [OUTPUT_RANGE_BITS-1:0] NEG_LIMIT =
        OUTPUT_RANGE_BITS'(clamp_neg_limit(OUTPUT_RANGE_BITS));

    // In-range results fit in the low bits; the upper bits carry only sign.
    logic unused_result_hi;
    assign unused_result_hi = ^pi_result[OUTPUT_WIDTH-1:OUTPUT_RANGE_BITS];

    // Overflow wins if the pipeline ever raises both flags.
    always_comb begin
        dac_word  = pi_result[OUTPUT_RANGE_BITS-1:0];
        clamped   = 1'b0;
        commit_en = 1'b1;
        if (overflow) begin
            dac_word  = POS_LIMIT;
            clamped   = 1'b1;
            commit_en = 1'b0;
        end else if (underflow) begin
            dac_word  = NEG_LIMIT;
            clamped   = 1'b1;
            commit_en = 1'b0;
        end
    end

endmodule

// File: rtl/pi_loop_sequencer.sv
// PI control-loop sequencer around an external PI arithmetic pipeline.
// One ADC sample per iteration: capture sample/setpoint/gains into hold
// registers driving the pipeline, wait out the pipeline latency, clamp the
// result into the DAC range, commit the integral (anti-windup: not on
// saturation) and hand one DAC word downstream over valid/ready.
// Ports:
//   clk, rst_L                 - clock, asynchronous active-low reset
//   enable, integral_clear     - run enable, clear stored integral (IDLE only)
//   sample_valid, sample_data  - ADC sample strobe and value
//   setpoint_in, kp_in, ki_in  - live loop parameters, sampled at capture
//   pipe_*  (out)              - held operands to the pipeline
//   pipe_*  (in)               - pipeline integral/result and range flags
//   dac_data, dac_valid, dac_ready - output word handshake
//   busy, clamped, dropped_count   - status
module pi_loop_sequencer
    import pi_pkg::*;
#(
    parameter int INPUT_WIDTH       = 18,
    parameter int OUTPUT_WIDTH      = 32,
    parameter int OUTPUT_RANGE_BITS = 20,
    parameter int PIPELINE_LATENCY  = DEFAULT_PIPELINE_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst_L,
    input  logic                         enable,
    input  logic                         integral_clear,
    input  logic                         sample_valid,
    input  logic [INPUT_WIDTH-1:0]       sample_data,
    input  logic [INPUT_WIDTH-1:0]       setpoint_in,
    input  logic [OUTPUT_WIDTH-1:0]      kp_in,
    input  logic [OUTPUT_WIDTH-1:0]      ki_in,
    output logic [INPUT_WIDTH-1:0]       pipe_actual,
    output logic [INPUT_WIDTH-1:0]       pipe_setpoint,
    output logic [OUTPUT_WIDTH-1:0]      pipe_kp,
    output logic [OUTPUT_WIDTH-1:0]      pipe_ki,
    output logic [OUTPUT_WIDTH-1:0]      pipe_integral,
    input  logic [OUTPUT_WIDTH-1:0]      pipe_integral_result,
    input  logic [OUTPUT_WIDTH-1:0]      pipe_pi_result,
    input  logic                         pipe_overflow,
    input  logic                         pipe_underflow,
    output logic [OUTPUT_RANGE_BITS-1:0] dac_data,
    output logic                         dac_valid,
    input  logic                         dac_ready,
    output logic                         busy,
    output logic                         clamped,
    output logic [15:0]                  dropped_count
);

    localparam int CW = $clog2(PIPELINE_LATENCY + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(PIPELINE_LATENCY);

    logic [1:0]                   state_reg,    state_next;
    logic [CW-1:0]                wait_cnt_reg, wait_cnt_next;
    logic [INPUT_WIDTH-1:0]       actual_reg;
    logic [INPUT_WIDTH-1:0]       setpoint_reg;
    logic [OUTPUT_WIDTH-1:0]      kp_reg;
    logic [OUTPUT_WIDTH-1:0]      ki_reg;
    logic [OUTPUT_WIDTH-1:0]      integral_reg;
    logic [OUTPUT_RANGE_BITS-1:0] dac_data_reg;
    logic                         dac_valid_reg;
    logic                         clamped_reg;
    logic [15:0]                  dropped_reg;

    logic                         capture;
    logic                         clear_integral;
    logic                         drop;
    logic                         take_result;
    logic                         transfer;

    logic [OUTPUT_RANGE_BITS-1:0] clamp_word;
    logic                         clamp_flag;
    logic                         commit_en;

    pi_output_clamp #(
        .OUTPUT_WIDTH      (OUTPUT_WIDTH),
        .OUTPUT_RANGE_BITS (OUTPUT_RANGE_BITS)
    ) u_clamp (
        .pi_result (pipe_pi_result),
        .overflow  (pipe_overflow),
        .underflow (pipe_underflow),
        .dac_word  (clamp_word),
        .clamped   (clamp_flag),
        .commit_en (commit_en)
    );

    // integral_clear pre-empts a coincident capture; any strobe that does not
    // start an iteration is a drop.
    always_comb begin
        clear_integral = (state_reg == ST_IDLE) && integral_clear;
        capture        = (state_reg == ST_IDLE) && enable && sample_valid && !integral_clear;
        drop           = sample_valid && !capture;
        take_result    = (state_reg == ST_WAIT) && (wait_cnt_reg == '0);
        transfer       = (state_reg == ST_OUTPUT) && dac_valid_reg && dac_ready;
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (capture) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (take_result) begin
                    state_next = ST_OUTPUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (transfer) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            actual_reg    <= '0;
            setpoint_reg  <= '0;
            kp_reg        <= '0;
            ki_reg        <= '0;
            integral_reg  <= '0;
            dac_data_reg  <= '0;
            dac_valid_reg <= 1'b0;
            clamped_reg   <= 1'b0;
            dropped_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;

            if (capture) begin
                actual_reg   <= sample_data;
                setpoint_reg <= setpoint_in;
                kp_reg       <= kp_in;
                ki_reg       <= ki_in;
            end

            if (clear_integral) begin
                integral_reg <= '0;
            end else if (take_result && commit_en) begin
                integral_reg <= pipe_integral_result;
            end

            if (take_result) begin
                dac_data_reg  <= clamp_word;
                clamped_reg   <= clamp_flag;
                dac_valid_reg <= 1'b1;
            end else if (transfer) begin
                dac_valid_reg <= 1'b0;
            end

            if (drop && (dropped_reg != 16'hFFFF)) begin
                dropped_reg <= dropped_reg + 16'd1;
            end
        end
    end

    assign pipe_actual   = actual_reg;
    assign pipe_setpoint = setpoint_reg;
    assign pipe_kp       = kp_reg;
    assign pipe_ki       = ki_reg;
    assign pipe_integral = integral_reg;
    assign dac_data      = dac_data_reg;
    assign dac_valid     = dac_valid_reg;
    assign clamped       = clamped_reg;
    assign dropped_count = dropped_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pi_loop_sequencer.sv
module tb_pi_loop_sequencer;

    localparam int IW  = 18;
    localparam int OW  = 32;
    localparam int R   = 20;
    localparam int LAT = 5;
    localparam longint POS = (64'sd1 <<< (R - 1)) - 1;
    localparam longint NEG = -(64'sd1 <<< (R - 1));

    logic          clk = 1'b0;
    logic          rst_L = 1'b1;
    logic          enable = 1'b0;
    logic          integral_clear = 1'b0;
    logic          sample_valid = 1'b0;
    logic [IW-1:0] sample_data = '0;
    logic [IW-1:0] setpoint_in = '0;
    logic [OW-1:0] kp_in = '0;
    logic [OW-1:0] ki_in = '0;
    logic          dac_ready = 1'b0;

    logic [IW-1:0] pipe_actual, pipe_setpoint;
    logic [OW-1:0] pipe_kp, pipe_ki, pipe_integral;
    logic [OW-1:0] pipe_integral_result, pipe_pi_result;
    logic          pipe_overflow, pipe_underflow;
    logic [R-1:0]  dac_data;
    logic          dac_valid, busy, clamped;
    logic [15:0]   dropped_count;

    int errors = 0;
    int checks = 0;
    int n_xfer = 0;

    always #5 clk = ~clk;

    pi_loop_sequencer #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUTPUT_RANGE_BITS(R), .PIPELINE_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_L(rst_L), .enable(enable), .integral_clear(integral_clear),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .setpoint_in(setpoint_in), .kp_in(kp_in), .ki_in(ki_in),
        .pipe_actual(pipe_actual), .pipe_setpoint(pipe_setpoint),
        .pipe_kp(pipe_kp), .pipe_ki(pipe_ki), .pipe_integral(pipe_integral),
        .pipe_integral_result(pipe_integral_result), .pipe_pi_result(pipe_pi_result),
        .pipe_overflow(pipe_overflow), .pipe_underflow(pipe_underflow),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .busy(busy), .clamped(clamped), .dropped_count(dropped_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PI arithmetic: error = actual - setpoint, integral' = integral + ki*error,
    // result = kp*error + integral'.
    function automatic longint pi_err(input logic [IW-1:0] act, input logic [IW-1:0] sp);
        return longint'($signed(act)) - longint'($signed(sp));
    endfunction

    // ---------------- stand-in arithmetic pipeline (LAT stages) ----------------
    logic [OW-1:0] st_int [LAT];
    logic [OW-1:0] st_pi  [LAT];
    logic          st_ov  [LAT];
    logic          st_un  [LAT];

    always @(posedge clk) begin
        longint e, ni, pv;
        e  = pi_err(pipe_actual, pipe_setpoint);
        ni = longint'($signed(pipe_integral)) + longint'($signed(pipe_ki)) * e;
        pv = longint'($signed(pipe_kp)) * e + ni;
        st_int[0] <= ni[OW-1:0];
        st_pi[0]  <= pv[OW-1:0];
        st_ov[0]  <= (pv > POS);
        st_un[0]  <= (pv < NEG);
        for (int i = 1; i < LAT; i++) begin
            st_int[i] <= st_int[i-1];
            st_pi[i]  <= st_pi[i-1];
            st_ov[i]  <= st_ov[i-1];
            st_un[i]  <= st_un[i-1];
        end
    end

    assign pipe_integral_result = st_int[LAT-1];
    assign pipe_pi_result       = st_pi[LAT-1];
    assign pipe_overflow        = st_ov[LAT-1];
    assign pipe_underflow       = st_un[LAT-1];

    always @(posedge clk) if (dac_valid && dac_ready) n_xfer++;

    // ---------------- behavioural model ----------------
    // m_age counts edges since capture: 0 = idle, LAT+2 = word on offer.
    int            m_age = 0;
    logic [IW-1:0] m_act = '0, m_sp = '0;
    logic [OW-1:0] m_kp = '0, m_ki = '0, m_integ = '0;
    logic [R-1:0]  m_dac = '0, p_dac = '0;
    logic          m_clamped = 1'b0, p_clamped = 1'b0;
    logic [OW-1:0] p_int = '0;
    logic [15:0]   m_drops = '0;

    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            m_age <= 0; m_act <= '0; m_sp <= '0; m_kp <= '0; m_ki <= '0;
            m_integ <= '0; m_dac <= '0; m_clamped <= 1'b0; m_drops <= '0;
        end else begin
            longint e, ni, pv;
            if (sample_valid && !(m_age == 0 && enable && !integral_clear) && m_drops != 16'hFFFF)
                m_drops <= m_drops + 16'd1;
            if (m_age == 0) begin
                if (integral_clear) begin
                    m_integ <= '0;
                end else if (enable && sample_valid) begin
                    m_act <= sample_data; m_sp <= setpoint_in; m_kp <= kp_in; m_ki <= ki_in;
                    e  = pi_err(sample_data, setpoint_in);
                    ni = longint'($signed(m_integ)) + longint'($signed(ki_in)) * e;
                    pv = longint'($signed(kp_in)) * e + ni;
                    if (pv > POS) begin
                        p_dac <= POS[R-1:0]; p_clamped <= 1'b1; p_int <= m_integ;
                    end else if (pv < NEG) begin
                        p_dac <= NEG[R-1:0]; p_clamped <= 1'b1; p_int <= m_integ;
                    end else begin
                        p_dac <= pv[R-1:0]; p_clamped <= 1'b0; p_int <= ni[OW-1:0];
                    end
                    m_age <= 1;
                end
            end else if (m_age < LAT + 2) begin
                m_age <= m_age + 1;
                if (m_age == LAT + 1) begin
                    m_dac <= p_dac; m_clamped <= p_clamped; m_integ <= p_int;
                end
            end else if (dac_ready) begin
                m_age <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",          {63'd0, busy},      {63'd0, (m_age != 0)});
        chk("dac_valid",     {63'd0, dac_valid}, {63'd0, (m_age == LAT + 2)});
        chk("dac_data",      64'(dac_data),      64'(m_dac));
        chk("clamped",       {63'd0, clamped},   {63'd0, m_clamped});
        chk("dropped_count", 64'(dropped_count), 64'(m_drops));
        chk("pipe_actual",   64'(pipe_actual),   64'(m_act));
        chk("pipe_setpoint", 64'(pipe_setpoint), 64'(m_sp));
        chk("pipe_kp",       64'(pipe_kp),       64'(m_kp));
        chk("pipe_ki",       64'(pipe_ki),       64'(m_ki));
        chk("pipe_integral", 64'(pipe_integral), 64'(m_integ));
    end

    // ---------------- directed stimulus with literal expectations ----------------
    // One iteration with dac_ready high; checks latency, word, flag, integral.
    task automatic run_iter(input string tag, input logic [IW-1:0] act,
                            input logic [R-1:0] exp_dac, input logic exp_clamp,
                            input logic [OW-1:0] exp_int, input logic drop_enable);
        int x0;
        x0 = n_xfer;
        @(posedge clk); #2;
        sample_data = act; sample_valid = 1'b1;
        @(posedge clk); #2;                  // capture edge N
        sample_valid = 1'b0;
        if (drop_enable) enable = 1'b0;
        chk({tag, " busy_after_capture"}, {63'd0, busy}, 64'd1);
        repeat (LAT) @(posedge clk); #2;     // edge N+5
        chk({tag, " valid_low_N5"}, {63'd0, dac_valid}, 64'd0);
        @(posedge clk); #2;                  // edge N+6
        chk({tag, " valid_N6"}, {63'd0, dac_valid}, 64'd1);
        chk({tag, " dac_data"}, 64'(dac_data), 64'(exp_dac));
        chk({tag, " clamped"}, {63'd0, clamped}, {63'd0, exp_clamp});
        chk({tag, " integral"}, 64'(pipe_integral), 64'(exp_int));
        @(posedge clk); #2;                  // edge N+7 transfer
        chk({tag, " idle_N7"}, {62'd0, busy, dac_valid}, 64'd0);
        chk({tag, " one_transfer"}, 64'(n_xfer - x0), 64'd1);
        $display("txn %s: act=%0d dac=%0h clamped=%0b integral=%0d", tag,
                 $signed(act), dac_data, clamped, $signed(pipe_integral));
    endtask

    initial begin
        #1 rst_L = 1'b0;
        #20;
        chk("reset outputs", {44'd0, dac_data}, 64'd0);
        chk("reset status", {45'd0, dropped_count, busy, dac_valid, clamped}, 64'd0);
        @(posedge clk); #2 rst_L = 1'b1;
        $display("txn reset released");

        enable = 1'b1; dac_ready = 1'b1;
        setpoint_in = '0; kp_in = 32'd2; ki_in = 32'd1;
        run_iter("basic1", 18'd100, 20'd300, 1'b0, 32'd100, 1'b0);
        run_iter("basic2", 18'd100, 20'd400, 1'b0, 32'd200, 1'b0);

        // integral_clear with a coincident strobe in IDLE
        @(posedge clk); #2;
        integral_clear = 1'b1; sample_valid = 1'b1; sample_data = 18'd100;
        @(posedge clk); #2;
        integral_clear = 1'b0; sample_valid = 1'b0;
        chk("clear integral", 64'(pipe_integral), 64'd0);
        chk("clear no capture", {63'd0, busy}, 64'd0);
        chk("clear dropped", 64'(dropped_count), 64'd1);
        $display("txn integral_clear: integral=%0d dropped=%0d", pipe_integral, dropped_count);

        kp_in = 32'd10000; ki_in = 32'd0;
        run_iter("overflow",  18'd100,            20'h7FFFF, 1'b1, 32'd0, 1'b0);
        run_iter("underflow", -18'sd100,          20'h80000, 1'b1, 32'd0, 1'b0);

        // backpressure: strobe every cycle, dac_ready low 10 cycles in OUTPUT
        kp_in = 32'd2; ki_in = 32'd1; dac_ready = 1'b0;
        begin
            int x0;
            x0 = n_xfer;
            @(posedge clk); #2;
            sample_data = 18'd100; sample_valid = 1'b1;
            @(posedge clk); #2;                       // capture edge N
            repeat (LAT + 1) @(posedge clk); #2;      // edge N+6
            for (int k = 0; k < 11; k++) begin
                chk("bp valid", {63'd0, dac_valid}, 64'd1);
                chk("bp data", 64'(dac_data), 64'd300);
                if (k < 10) begin @(posedge clk); #2; end
            end
            dac_ready = 1'b1;                         // after edge N+16
            @(posedge clk); #2;                       // edge N+17 transfer
            sample_valid = 1'b0;
            chk("bp single transfer", 64'(n_xfer - x0), 64'd1);
            chk("bp idle", {62'd0, busy, dac_valid}, 64'd0);
            chk("bp dropped", 64'(dropped_count), 64'd18);
            chk("bp integral", 64'(pipe_integral), 64'd100);
            $display("txn backpressure: dac=%0d dropped=%0d", dac_data, dropped_count);
        end

        // reset in the middle of WAIT
        @(posedge clk); #2;
        sample_data = 18'd100; sample_valid = 1'b1;
        @(posedge clk); #2;                           // capture edge N
        sample_valid = 1'b0;
        repeat (3) @(posedge clk); #2;                // N+3
        rst_L = 1'b0;
        #1;
        chk("rst immediate status", {62'd0, busy, dac_valid}, 64'd0);
        chk("rst integral", 64'(pipe_integral), 64'd0);
        chk("rst dac_data", 64'(dac_data), 64'd0);
        repeat (2) @(posedge clk); #2;
        rst_L = 1'b1;
        repeat (8) begin
            @(posedge clk); #2;
            chk("rst no valid", {63'd0, dac_valid}, 64'd0);
        end
        chk("rst dropped", 64'(dropped_count), 64'd0);
        $display("txn reset mid-wait: busy=%0b integral=%0d", busy, pipe_integral);

        run_iter("after_reset", 18'd100, 20'd300, 1'b0, 32'd100, 1'b0);
        run_iter("enable_drop", 18'd100, 20'd400, 1'b0, 32'd200, 1'b1);

        // strobe with enable low: dropped, no capture
        @(posedge clk); #2;
        sample_valid = 1'b1;
        @(posedge clk); #2;
        sample_valid = 1'b0;
        chk("disabled no capture", {63'd0, busy}, 64'd0);
        chk("disabled dropped", 64'(dropped_count), 64'd1);
        $display("txn disabled strobe: dropped=%0d", dropped_count);

        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
